// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter/sequencer for the shared 16-bit ALU.
// A transaction is accepted in IDLE, its operands are presented to the ALU
// in ISSUE, and the captured result/flags are returned in RESP until the
// granted requester takes them. Only one transaction is in flight at a time.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req{0,1}_valid/ready        request handshake per requester
//   req{0,1}_a/b/op             requester operands and opcode
//   rsp{0,1}_valid/ready        response handshake per requester
//   rsp_result, rsp_flags       shared captured result, {overflow, carry, zero}
//   alu_a/b/op                  operands/opcode to the ALU
//   alu_result/zero/carry/overflow  results from the ALU
//   busy                        high whenever not IDLE
module alu_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        rr_ptr;
  logic        gnt_id;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_code;
  logic [15:0] res_q;
  logic [2:0]  flags_q;
  logic        pick1;
  logic        accept;
  logic        rsp_done;

  always_comb begin
    state_nxt  = state;
    pick1      = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        // Requester 1 wins when it is alone, or when both contend and rr_ptr points at it.
        pick1      = req1_valid & (~req0_valid | rr_ptr);
        accept     = req0_valid | req1_valid;
        req0_ready = req0_valid & ~pick1;
        req1_ready = pick1;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = RESP;
      RESP: begin
        // Only the granted requester's ready can complete the response.
        rsp_done = gnt_id ? rsp1_ready : rsp0_ready;
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Handshake outputs are forced low for the whole time reset is asserted.
    if (!rst_n) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      gnt_id  <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        op_a    <= pick1 ? req1_a  : req0_a;
        op_b    <= pick1 ? req1_b  : req0_b;
        op_code <= pick1 ? req1_op : req0_op;
        gnt_id  <= pick1;
      end
      if (state == ISSUE) begin
        res_q   <= alu_result;
        flags_q <= {alu_overflow, alu_carry, alu_zero};
      end
      if (rsp_done) rr_ptr <= ~gnt_id;
    end
  end

  assign rsp0_valid = rst_n & (state == RESP) & ~gnt_id;
  assign rsp1_valid = rst_n & (state == RESP) &  gnt_id;
  assign busy       = rst_n & (state != IDLE);
  assign alu_a      = rst_n ? op_a    : '0;
  assign alu_b      = rst_n ? op_b    : '0;
  assign alu_op     = rst_n ? op_code : '0;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 16-bit ALU. Two independent requesters submit operand/opcode transactions over valid/ready handshakes. The block grants the ALU round-robin, drives the ALU inputs from registered operands, captures the result and flags, and returns them to the granted requester over a held response handshake. It sits between the ALU's combinational `a/b/op_code -> result/flags` ports and the two client blocks.

## Interface
- No parameters. Widths are fixed: data 16, opcode 4, flags 3.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a transaction.
- `req0_ready` out 1: requester 0 transaction accepted this cycle.
- `req0_a`, `req0_b` in 16: requester 0 operands.
- `req0_op` in 4: requester 0 ALU opcode.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as above, for requester 1.
- `rsp0_valid` out 1: response pending for requester 0.
- `rsp0_ready` in 1: requester 0 takes the response.
- `rsp1_valid` out 1, `rsp1_ready` in 1: same, for requester 1.
- `rsp_result` out 16: shared captured ALU result.
- `rsp_flags` out 3: shared captured flags, packed {overflow, carry, zero}.
- `alu_a`, `alu_b` out 16: to ALU operand inputs.
- `alu_op` out 4: to ALU `op_code`.
- `alu_result` in 16, `alu_zero`, `alu_carry`, `alu_overflow` in 1: from ALU.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Three states:
  - **IDLE.** If neither valid is high, stay in IDLE. Otherwise grant one requester:
    - only one valid high: that requester wins;
    - both high: the requester selected by `rr_ptr` wins.
    - Assert the winner's `reqN_ready` combinationally in the same cycle. The loser's ready stays low.
    - At the clock edge, latch the winner's a/b/op into the operand registers and the winner id into `gnt_id`. Go to ISSUE.
  - **ISSUE.** `alu_a/alu_b/alu_op` are driven from the operand registers for the whole cycle. At the clock edge, capture `alu_result` and {`alu_overflow`, `alu_carry`, `alu_zero`} into the response registers. Go to RESP.
  - **RESP.** `rsp<gnt_id>_valid` is high and the other `rspN_valid` is low.
    - `rsp_result/rsp_flags` hold stable until the handshake completes.
    - When `rsp<gnt_id>_ready` is high: go to IDLE and set `rr_ptr = ~gnt_id`.
    - The non-granted `rspN_ready` is ignored.
- `reqN_ready` is low in ISSUE and RESP. No new request is accepted while a transaction is outstanding; depth is one.
- The operand registers always drive `alu_a/b/op`. They keep their last issued values in IDLE and RESP.
- Opcodes are passed through unchecked. Undefined opcodes (12-15) return whatever the ALU produces (result 0x0000, flags 3'b001).
- A requester holding `valid` high across a grant gets a new transaction only on its next IDLE acceptance. Each ready pulse accepts exactly one transaction.
- Fairness: under continuous contention, grants alternate 0,1,0,1.

## Timing
- Latency from request accepted (IDLE edge) to `rsp_valid` high: 2 edges. Response data is visible in the cycle after ISSUE.
- Minimum spacing between acceptances: 3 cycles (IDLE, ISSUE, RESP with ready already high).
- `rsp_valid` is a registered state decode. `req_ready` is a combinational decode of state, valids and `rr_ptr`.
- Reset (`rst_n` low at an edge), from any state including mid-ISSUE or RESP:
  - state goes to IDLE, `rr_ptr` = 0, `gnt_id` = 0;
  - operand registers, `rsp_result` and `rsp_flags` cleared to 0;
  - outstanding transaction and response discarded.
- Output values while `rst_n` is low:
  - `req*_ready`, `rsp*_valid`, `busy` are 0;
  - `alu_a`, `alu_b`, `alu_op` are 0.
- In the first IDLE cycle after reset release, a request can be accepted.

## Test plan
- **Single ADD.** req0: a=0x7FFF, b=0x0001, op=0000.
  - req0_ready pulses 1 cycle.
  - 2 edges later: rsp0_valid=1, rsp_result=0x8000, rsp_flags=3'b100.
  - rsp1_valid stays 0.
- **Simultaneous requests after reset.** req0 SUB 5-7; req1 MUL 0x0100*0x0100.
  - req0 granted first: result 0xFFFE, flags 3'b010.
  - Then req1: result 0x0000, flags 3'b011.
  - Next contention grants req0.
- **Response backpressure.** rsp1_ready held low 5 cycles in RESP.
  - rsp1_valid, rsp_result, rsp_flags stay stable.
  - req0_ready stays 0 throughout, with req0_valid high.
  - Release ready: IDLE next, then req0 is accepted.
- **Continuous contention, 8 transactions.** Grant order is 0,1,0,1,0,1,0,1. Every result matches the golden ALU model.
- **Reset mid-operation.** rst_n low during ISSUE, then during RESP.
  - Next cycle: all valids/readies 0, busy 0, rsp_result 0, alu_a/b/op 0.
  - After release, a req1 request is accepted immediately with correct result.
- **Shift/undefined opcodes.**
  - SHL a=0x8001, b=1 -> result 0x0002, flags 3'b010.
  - op=1111 -> result 0x0000, flags 3'b001.
